// File: rtl/bn_scale_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : bn_scale_multiplier_if
//  Description : Handshake / configuration bundle for bn_scale_multiplier.
//                master = producer/consumer side (testbench or upstream),
//                slave  = multiplier side.
//  Signals     : cfg_we/cfg_addr/cfg_data   scale-table write port
//                in_valid/in_ready/in_sof/in_data  activation input stream
//                out_valid/out_ready/out_data/out_channel/overflow/underflow
//                                           product output stream
//  Revision    : 1.0 - initial release
// ============================================================================
interface bn_scale_multiplier_if #(
    parameter int XLEN = 32,
    parameter int CH_W = 3
);
    logic            cfg_we;
    logic [CH_W-1:0] cfg_addr;
    logic [XLEN-1:0] cfg_data;

    logic            in_valid;
    logic            in_ready;
    logic            in_sof;
    logic [XLEN-1:0] in_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [CH_W-1:0] out_channel;
    logic            overflow;
    logic            underflow;

    modport master (
        output cfg_we, cfg_addr, cfg_data,
        output in_valid, in_sof, in_data,
        input  in_ready,
        output out_ready,
        input  out_valid, out_data, out_channel, overflow, underflow
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data,
        input  in_valid, in_sof, in_data,
        output in_ready,
        input  out_ready,
        output out_valid, out_data, out_channel, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/bn_scale_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : bn_scale_multiplier
//  Description : 3-stage pipelined FP32 multiplier y = x * scale[ch] for the
//                batch-normalization datapath. Keeps a per-channel scale table
//                and forwards the channel index of each result.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - bn_scale_multiplier_if.slave (cfg write port, input
//                        stream with sof, output stream with channel and
//                        overflow/underflow flags)
//  Option      : BN_SCALE_MULT_RNE_EN - when defined, round-to-nearest-even
//                on the discarded product bits; otherwise truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module bn_scale_multiplier #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bn_scale_multiplier_if.slave bus
);
    localparam logic [XLEN-1:0] c_ONE     = XLEN'(32'h3F80_0000);
    localparam logic [CH_W-1:0] c_LAST_CH = CH_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // Handshake: one global stall freezes every pipeline stage.
    // ------------------------------------------------------------------
    logic out_valid_q;
    logic w_advance;
    logic w_accept;

    assign w_advance    = !(out_valid_q && !bus.out_ready);
    assign w_accept     = bus.in_valid && w_advance;
    assign bus.in_ready = w_advance;

    // ------------------------------------------------------------------
    // Scale table. Writes are independent of the stall; a read in the
    // same cycle as a write returns the old entry.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] scale_q [NUM_CH];
    logic [XLEN-1:0] w_scale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) scale_q[i] <= c_ONE;
        end else if (bus.cfg_we) begin
            // Addresses at or beyond NUM_CH match no entry and are dropped.
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.cfg_addr == CH_W'(i)) scale_q[i] <= bus.cfg_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel tracking
    // ------------------------------------------------------------------
    logic [CH_W-1:0] ch_cnt_q;
    logic [CH_W-1:0] ch_cnt_d;
    logic [CH_W-1:0] w_ch;

    assign w_ch     = bus.in_sof ? '0 : ch_cnt_q;
    assign ch_cnt_d = (w_ch == c_LAST_CH) ? '0 : w_ch + 1'b1;

    always_comb begin
        w_scale = c_ONE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == CH_W'(i)) w_scale = scale_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ch_cnt_q <= '0;
        else if (w_accept) ch_cnt_q <= ch_cnt_d;
    end

    // ------------------------------------------------------------------
    // Stage 1: unpack. Exponent sum kept as 10-bit two's complement.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_x;
    logic            w_zero;
    logic [9:0]      w_exp_sum;

    assign w_x       = bus.in_data;
    // Denormals have exponent 0 and are therefore treated as zero.
    assign w_zero    = (w_x[30:23] == 8'd0) || (w_scale[30:23] == 8'd0);
    assign w_exp_sum = {2'b00, w_x[30:23]} + {2'b00, w_scale[30:23]} - 10'd127;

    logic            s1_valid_q, s1_sign_q, s1_zero_q;
    logic [9:0]      s1_exp_q;
    logic [23:0]     s1_mx_q, s1_ms_q;
    logic [CH_W-1:0] s1_ch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mx_q    <= '0;
            s1_ms_q    <= '0;
            s1_ch_q    <= '0;
        end else if (w_advance) begin
            s1_valid_q <= w_accept;
            s1_sign_q  <= w_x[31] ^ w_scale[31];
            s1_zero_q  <= w_zero;
            s1_exp_q   <= w_exp_sum;
            s1_mx_q    <= {1'b1, w_x[22:0]};
            s1_ms_q    <= {1'b1, w_scale[22:0]};
            s1_ch_q    <= w_ch;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: 24x24 mantissa product
    // ------------------------------------------------------------------
    logic            s2_valid_q, s2_sign_q, s2_zero_q;
    logic [9:0]      s2_exp_q;
    logic [47:0]     s2_prod_q;
    logic [CH_W-1:0] s2_ch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_prod_q  <= '0;
            s2_ch_q    <= '0;
        end else if (w_advance) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= s1_zero_q;
            s2_exp_q   <= s1_exp_q;
            s2_prod_q  <= {24'd0, s1_mx_q} * {24'd0, s1_ms_q};
            s2_ch_q    <= s1_ch_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalize, round/truncate, range-check, pack
    // ------------------------------------------------------------------
    logic [9:0]  w_exp_n, w_exp_f;
    logic [22:0] w_mant, w_mant_f;

    // Product of two [1,2) mantissas lies in [1,4); bit 47 flags the upper half.
    assign w_exp_n = s2_exp_q + {9'd0, s2_prod_q[47]};
    assign w_mant  = s2_prod_q[47] ? s2_prod_q[46:24] : s2_prod_q[45:23];

`ifdef BN_SCALE_MULT_RNE_EN
    logic        w_guard, w_sticky, w_round_up;
    logic [23:0] w_mant_inc;

    assign w_guard    = s2_prod_q[47] ? s2_prod_q[23]  : s2_prod_q[22];
    assign w_sticky   = s2_prod_q[47] ? |s2_prod_q[22:0] : |s2_prod_q[21:0];
    assign w_round_up = w_guard && (w_sticky || w_mant[0]);
    assign w_mant_inc = {1'b0, w_mant} + {23'd0, w_round_up};
    // A carry out of the fraction means 1.111..1 rounded to 10.000..0.
    assign w_mant_f   = w_mant_inc[22:0];
    assign w_exp_f    = w_exp_n + {9'd0, w_mant_inc[23]};
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^s2_prod_q[22:0];
    assign w_mant_f      = w_mant;
    assign w_exp_f       = w_exp_n;
`endif

    logic [XLEN-1:0] out_data_d;
    logic            ovf_d, unf_d;

    always_comb begin
        out_data_d = {s2_sign_q, w_exp_f[7:0], w_mant_f};
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        if (s2_zero_q) begin
            out_data_d = {s2_sign_q, 31'd0};
        end else if ($signed(w_exp_f) >= 10'sd255) begin
            out_data_d = {s2_sign_q, 8'hFF, 23'd0};
            ovf_d      = 1'b1;
        end else if ($signed(w_exp_f) <= 10'sd0) begin
            out_data_d = {s2_sign_q, 31'd0};
            unf_d      = 1'b1;
        end
    end

    logic [XLEN-1:0] out_data_q;
    logic [CH_W-1:0] out_ch_q;
    logic            ovf_q, unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (w_advance) begin
            out_valid_q <= s2_valid_q;
            out_data_q  <= out_data_d;
            out_ch_q    <= s2_ch_q;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_ch_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule
`default_nettype wire
